seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 14 +
 rtl/hex_to_7seg.sv | 15 +
 rtl/seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and hex font for the 7-segment scan controller
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, GAP, DRIVE} state_t;

  typedef logic [6:0] seg_t;

  // Active-high {g,f,e,d,c,b,a} codes for 0-9, A, b, C, d, E, F
  localparam seg_t HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to 7-segment decoder
module hex_to_7seg
  import seg_scan_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = ACTIVE_LOW ? ~HEX_FONT[nibble] : HEX_FONT[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronous update
// Optional decimal point support when SEG_SCAN_DP_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_CYCLES   = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIG_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST  = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam state_t        GAP_ENTRY  = (DEAD_CYCLES == 0) ? DRIVE : GAP;

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be in 1..8");
  end
  if (DIGIT_CYCLES < 1) begin : g_bad_digit_cycles
    $error("seg_scan_ctrl: DIGIT_CYCLES must be >= 1");
  end
  if (DEAD_CYCLES < 0) begin : g_bad_dead_cycles
    $error("seg_scan_ctrl: DEAD_CYCLES must be >= 0");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   digit_idx, digit_nxt;
  logic            commit;

  logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
  logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;
  logic                    pend_valid;
  logic                    take_direct, take_pend;

  logic [3:0]              sel_nibble;
  logic [6:0]              seg_dec, seg_d;
  logic [NUM_DIGITS-1:0]   an_hot, an_d;
  logic                    lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= digit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    digit_nxt = digit_idx;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      digit_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GAP_ENTRY;
          cnt_nxt   = '0;
          digit_nxt = '0;
        end
        GAP: begin
          if (cnt == DEAD_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DIG_LAST) begin
            state_nxt = GAP_ENTRY;
            cnt_nxt   = '0;
            digit_nxt = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          digit_nxt = '0;
        end
      endcase
    end
  end

  assign commit = enable && (state == DRIVE) && (cnt == DIG_LAST) && (digit_idx == LAST_DIGIT);

  // While idle there is no frame to tear, so data goes straight to the display buffer
  assign take_direct = (state == IDLE) && load;
  assign take_pend   = pend_valid && (((state == IDLE) && !load) || commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data  <= '0;
      pend_blank <= '0;
      disp_data  <= '0;
      disp_blank <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_data  <= data_in;
        pend_blank <= blank_mask;
      end
      if (take_direct) begin
        disp_data  <= data_in;
        disp_blank <= blank_mask;
      end else if (take_pend) begin
        disp_data  <= pend_data;
        disp_blank <= pend_blank;
      end
      if (state == IDLE) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  hex_to_7seg #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
  ) u_dec (
    .nibble (sel_nibble),
    .seg    (seg_dec)
  );

  always_comb begin
    sel_nibble = disp_data[{digit_idx, 2'b00} +: 4];
    lit        = enable && (state == DRIVE) && !disp_blank[digit_idx];
    an_hot     = lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
    an_d       = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    seg_d      = lit ? seg_dec : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= commit;
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp;
  logic                  dp_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dp <= '0;
      disp_dp <= '0;
    end else begin
      if (load) pend_dp <= dp_in;
      if (take_direct) disp_dp <= dp_in;
      else if (take_pend) disp_dp <= pend_dp;
    end
  end

  assign dp_on = lit && disp_dp[digit_idx];

  always_ff @(posedge clk) begin
    if (rst) dp <= (SEG_ACTIVE_LOW != 0);
    else     dp <= (SEG_ACTIVE_LOW != 0) ? !dp_on : dp_on;
  end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (dp checks when SEG_SCAN_DP_EN is defined)
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIG   = 4;
  localparam int DEAD  = 1;
  localparam int SLOT  = DIG + DEAD;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
`ifdef SEG_SCAN_DP_EN
  logic        dp;
`endif

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS     (N),
    .DIGIT_CYCLES   (DIG),
    .DEAD_CYCLES    (DEAD),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
`ifdef SEG_SCAN_DP_EN
    .dp_in      (dp_in),
    .dp         (dp),
`endif
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;

  // Reference state: m_s is the scan position reached after the last edge, -1 when idle
  int          m_s;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_blank, m_pblank, m_dp, m_pdp;
  logic        m_pv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_push();
    exp_t       e;
    int         dg;
    logic       commit;
    logic [3:0] oh;
    logic [3:0] nib;
    e.seg = 7'h7F;
    e.an  = 4'hF;
    e.fd  = 1'b0;
    e.dp  = 1'b1;
    if (rst) begin
      m_s = -1; m_disp = '0; m_pend = '0; m_blank = '0; m_pblank = '0;
      m_dp = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      commit = enable && (m_s >= 0) && ((m_s % FRAME) == FRAME - 1);
      if (enable && m_s >= 0) begin
        dg = (m_s % FRAME) / SLOT;
        if ((m_s % SLOT) >= DEAD && !m_blank[dg]) begin
          oh    = 4'b0001 << dg;
          nib   = m_disp[dg*4 +: 4];
          e.an  = ~oh;
          e.seg = ~FONT[nib];
          e.dp  = ~m_dp[dg];
        end
      end
      e.fd = commit;
      if (m_s < 0) begin
        if (load) begin
          m_disp = data_in; m_blank = blank_mask; m_dp = dp_in;
          m_pend = data_in; m_pblank = blank_mask; m_pdp = dp_in;
        end else if (m_pv) begin
          m_disp = m_pend; m_blank = m_pblank; m_dp = m_pdp;
        end
        m_pv = 1'b0;
      end else begin
        if (commit && m_pv) begin
          m_disp = m_pend; m_blank = m_pblank; m_dp = m_pdp;
        end
        if (load) begin
          m_pend = data_in; m_pblank = blank_mask; m_pdp = dp_in; m_pv = 1'b1;
        end else if (commit) begin
          m_pv = 1'b0;
        end
      end
      if (!enable)      m_s = -1;
      else if (m_s < 0) m_s = 0;
      else              m_s = (m_s + 1) % FRAME;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    exp_t e;
    load    = ld;
    data_in = d;
    model_push();
    @(posedge clk);
    #1;
    load = 1'b0;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("seg", {25'd0, seg}, {25'd0, e.seg});
      check("an", {28'd0, an}, {28'd0, e.an});
      check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
`ifdef SEG_SCAN_DP_EN
      check("dp", {31'd0, dp}, {31'd0, e.dp});
`endif
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, data_in);
  endtask

  task automatic run_until_pos(input int pos);
    int guard;
    guard = 0;
    while (m_s != pos && guard < 2 * FRAME) begin
      step(1'b0, data_in);
      guard++;
    end
    if (m_s != pos) check("pos_reached", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0;
    data_in = '0; blank_mask = '0; dp_in = '0;
    m_s = -1; m_pv = 1'b0;

    run(3);

    rst = 1'b0; enable = 1'b0; dp_in = 4'b0001;
    step(1'b1, 16'h3210);
    run(2);

    enable = 1'b1;
    fd_cnt = 0;
    run(2);
    step(1'b0, data_in);
    check("seg_digit0", {25'd0, seg}, 32'h40);
    run(38);
    check("frame_done_count", fd_cnt, 2);

    dp_in = 4'b0000;
    run(7);
    step(1'b1, 16'hFFFF);
    run(3);
    step(1'b1, 16'h8888);
    run(2 * FRAME);

    run_until_pos(6);
    step(1'b1, 16'hAAAA);
    run_until_pos(FRAME - 1);
    step(1'b1, 16'h5555);
    run(2 * FRAME + 2);

    blank_mask = 4'b0100;
    dp_in = 4'b0101;
    step(1'b1, 16'h9C4B);
    run(2 * FRAME);
    run_until_pos(2 * SLOT + 2);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(FRAME + 5);

    for (int k = 0; k < 10; k++) begin
      blank_mask = 4'($urandom_range(0, 15));
      dp_in      = 4'($urandom_range(0, 15));
      step(1'b1, 16'($urandom));
      run($urandom_range(3, 15));
    end
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
